// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: geometry, entry layout and the
// control-unit stall bit positions that feed stall_push / stall_pop.
package issue_queue_pkg;

    typedef logic bool;
    localparam bool TRUE  = 1'b1;
    localparam bool FALSE = 1'b0;

    localparam int IQ_DEPTH   = 8;
    localparam int IQ_PTR_W   = 3;
    localparam int IQ_CNT_W   = 4;
    localparam int IQ_ENTRY_W = 64;

    localparam logic [IQ_CNT_W-1:0] IQ_FULL_CNT = 4'd8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    // Positions within the control unit's stall_signal vector
    localparam int STALL_SIGNAL_W = 4;
    localparam int STALL_IQ_BIT   = 3;
    localparam int STALL_IS_BIT   = 2;

endpackage

// File: rtl/issue_queue_if.sv
// Handshake bundle between the id-is register / control unit and the issue stage.
interface issue_queue_if;
    import issue_queue_pkg::*;

    logic                in_valid;
    iq_entry_t           in_data;
    logic                stall_push;
    logic                stall_pop;
    logic                flash;
    logic                out_valid;
    iq_entry_t           out_data;
    logic                stall_from_issue;
    logic [IQ_CNT_W-1:0] count;

    modport slave (
        input  in_valid, in_data, stall_push, stall_pop, flash,
        output out_valid, out_data, stall_from_issue, count
    );

    modport master (
        output in_valid, in_data, stall_push, stall_pop, flash,
        input  out_valid, out_data, stall_from_issue, count
    );
endinterface

// File: rtl/issue_queue.sv
// Eight-entry circular issue queue; all outputs come from registered state,
// so a newly pushed entry becomes visible one cycle after its push edge.
module issue_queue
    import issue_queue_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    issue_queue_if.slave  bus
);

    iq_entry_t           mem_q [IQ_DEPTH];
    logic [IQ_PTR_W-1:0] head_q, head_d;
    logic [IQ_PTR_W-1:0] tail_q, tail_d;
    logic [IQ_CNT_W-1:0] count_q, count_d;

    logic push_en;
    logic pop_en;
    logic full;
    logic empty;

    assign full  = (count_q == IQ_FULL_CNT);
    assign empty = (count_q == '0);

    // A full queue refuses pushes even when the head leaves this same cycle
    always_comb begin
        push_en = bus.in_valid && !bus.stall_push && !bus.flash && !full;
        pop_en  = !empty && !bus.stall_pop && !bus.flash;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_en) tail_d = tail_q + 3'd1;
            if (pop_en)  head_d = head_q + 3'd1;
            if (push_en && !pop_en)      count_d = count_q + 4'd1;
            else if (pop_en && !push_en) count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; rst blocks the write so a reset edge
    // cannot leave a stray entry behind the cleared pointers.
    always_ff @(posedge clk) begin
        if (push_en && !rst) begin
            mem_q[tail_q] <= bus.in_data;
        end
    end

    always_comb begin
        bus.out_valid        = !empty;
        bus.out_data         = mem_q[head_q];
        bus.stall_from_issue = full;
        bus.count            = count_q;
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue.
module tb_issue_queue;
    import issue_queue_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    issue_queue_if iq_if ();

    issue_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (iq_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    // Push n entries base+0 .. base+n-1 with the issue stage stalled
    task automatic push_n(input logic [63:0] base, input int n);
        iq_if.stall_pop = 1'b1;
        for (int i = 0; i < n; i++) begin
            iq_if.in_valid = 1'b1;
            iq_if.in_data  = base + 64'(i);
            step();
        end
        iq_if.in_valid = 1'b0;
    endtask

    task automatic do_flash();
        iq_if.flash = 1'b1;
        step();
        iq_if.flash = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst               = 1'b1;
        iq_if.in_valid    = 1'b0;
        iq_if.in_data     = '0;
        iq_if.stall_push  = 1'b0;
        iq_if.stall_pop   = 1'b0;
        iq_if.flash       = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_count", 64'(iq_if.count), 64'd0);
        chk("rst_valid", 64'(iq_if.out_valid), 64'd0);
        chk("rst_full", 64'(iq_if.stall_from_issue), 64'd0);

        // stall_push blocks enqueue
        iq_if.stall_push = 1'b1;
        iq_if.in_valid   = 1'b1;
        iq_if.in_data    = 64'hDEAD_0000_0000_0001;
        step();
        iq_if.stall_push = 1'b0;
        iq_if.in_valid   = 1'b0;
        chk("stallpush_cnt", 64'(iq_if.count), 64'd0);

        // Three pushes, head visible one cycle after first push
        iq_if.stall_pop = 1'b1;
        iq_if.in_valid  = 1'b1;
        iq_if.in_data   = 64'h1000_0000_0000_0001;
        chk("empty_latency", 64'(iq_if.out_valid), 64'd0);
        step();
        chk("first_vis", iq_if.out_data, 64'h1000_0000_0000_0001);
        iq_if.in_valid = 1'b0;
        push_n(64'h1000_0000_0000_0002, 2);
        chk("p3_count", 64'(iq_if.count), 64'd3);
        chk("p3_head", iq_if.out_data, 64'h1000_0000_0000_0001);
        chk("p3_full", 64'(iq_if.stall_from_issue), 64'd0);
        do_flash();

        // Fill, refused 9th push, then drain in order
        push_n(64'h2000_0000_0000_0000, 8);
        chk("fill_count", 64'(iq_if.count), 64'd8);
        chk("fill_full", 64'(iq_if.stall_from_issue), 64'd1);
        iq_if.in_valid = 1'b1;
        iq_if.in_data  = 64'h2000_0000_0000_00FF;
        step();
        iq_if.in_valid = 1'b0;
        chk("ninth_count", 64'(iq_if.count), 64'd8);
        iq_if.stall_pop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", 64'(iq_if.out_valid), 64'd1);
            chk("drain_data", iq_if.out_data, 64'h2000_0000_0000_0000 + 64'(i));
            step();
        end
        chk("drain_count", 64'(iq_if.count), 64'd0);
        chk("drain_valid0", 64'(iq_if.out_valid), 64'd0);

        // Full with simultaneous pop and push attempt
        push_n(64'h3000_0000_0000_0000, 8);
        iq_if.stall_pop = 1'b0;
        iq_if.in_valid  = 1'b1;
        iq_if.in_data   = 64'h3000_0000_0000_00AA;
        step();
        iq_if.in_valid  = 1'b0;
        iq_if.stall_pop = 1'b1;
        chk("fullpp_count", 64'(iq_if.count), 64'd7);
        chk("fullpp_full", 64'(iq_if.stall_from_issue), 64'd0);
        chk("fullpp_head", iq_if.out_data, 64'h3000_0000_0000_0001);
        do_flash();

        // Steady push/pop at count=4 across pointer wrap
        push_n(64'h4000_0000_0000_0000, 4);
        iq_if.stall_pop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            iq_if.in_valid = 1'b1;
            iq_if.in_data  = 64'h4000_0000_0000_0004 + 64'(i);
            chk("stream_head", iq_if.out_data, 64'h4000_0000_0000_0000 + 64'(i));
            step();
            chk("stream_count", 64'(iq_if.count), 64'd4);
        end
        iq_if.in_valid = 1'b0;
        for (int i = 20; i < 24; i++) begin
            chk("stream_tail", iq_if.out_data, 64'h4000_0000_0000_0000 + 64'(i));
            step();
        end
        chk("stream_empty", 64'(iq_if.count), 64'd0);

        // Flash at count=5 overrides push and pop
        push_n(64'h5000_0000_0000_0000, 5);
        chk("c5_count", 64'(iq_if.count), 64'd5);
        iq_if.flash     = 1'b1;
        iq_if.in_valid  = 1'b1;
        iq_if.stall_pop = 1'b0;
        iq_if.in_data   = 64'h5000_0000_0000_00EE;
        step();
        iq_if.flash    = 1'b0;
        iq_if.in_valid = 1'b0;
        chk("flash_count", 64'(iq_if.count), 64'd0);
        chk("flash_valid", 64'(iq_if.out_valid), 64'd0);
        push_n(64'h5000_0000_0000_00AB, 1);
        chk("postfl_count", 64'(iq_if.count), 64'd1);
        chk("postfl_head", iq_if.out_data, 64'h5000_0000_0000_00AB);

        // Reset on a full queue beats a concurrent push
        push_n(64'h6000_0000_0000_0000, 7);
        chk("c8_count", 64'(iq_if.count), 64'd8);
        rst            = 1'b1;
        iq_if.in_valid = 1'b1;
        iq_if.in_data  = 64'h6000_0000_0000_00CC;
        step();
        rst            = 1'b0;
        iq_if.in_valid = 1'b0;
        chk("rstfull_count", 64'(iq_if.count), 64'd0);
        chk("rstfull_valid", 64'(iq_if.out_valid), 64'd0);
        chk("rstfull_full", 64'(iq_if.stall_from_issue), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
